// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit: one-cycle 32x32 multiply, 32-step restoring
// divide with a trailing sign-fix cycle. Results are held on hi/lo until the next op completes.
module muldiv_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_DIV = 2'b10;

   state_t      r_state;
   state_t      w_next;

   logic [1:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_dvsr;
   logic [63:0] r_rem;
   logic [63:0] r_hilo;
   logic [4:0]  r_cnt;

   logic        w_accept;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_mul_signed;
   logic [63:0] w_mul_a;
   logic [63:0] w_mul_b;
   logic [63:0] w_prod;
   logic [32:0] w_top;
   logic [32:0] w_trial;
   logic [63:0] w_rem_next;
   logic [31:0] w_quo;
   logic [31:0] w_rmd;
   logic        w_neg_q;
   logic        w_neg_r;
   logic [63:0] w_div_res;

   assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && valid && !flush;

   // Signed DIV works on magnitudes; the wrapping negation makes |0x80000000| = 0x80000000.
   assign w_a_mag = ((op == OP_DIV) && a[31]) ? (~a + 32'd1) : a;
   assign w_b_mag = ((op == OP_DIV) && b[31]) ? (~b + 32'd1) : b;

   assign w_mul_signed = ~r_op[0];
   assign w_mul_a      = {{32{w_mul_signed & r_a[31]}}, r_a};
   assign w_mul_b      = {{32{w_mul_signed & r_b[31]}}, r_b};
   assign w_prod       = w_mul_a * w_mul_b;

   // Partial remainder lives in r_rem[63:32], quotient bits shift in at r_rem[0].
   assign w_top      = r_rem[63:31];
   assign w_trial    = w_top - {1'b0, r_dvsr};
   assign w_rem_next = w_trial[32] ? {r_rem[62:0], 1'b0}
                                   : {w_trial[31:0], r_rem[30:0], 1'b1};

   assign w_quo   = r_rem[31:0];
   assign w_rmd   = r_rem[63:32];
   assign w_neg_q = (r_op == OP_DIV) && (r_a[31] ^ r_b[31]);
   assign w_neg_r = (r_op == OP_DIV) && r_a[31];
   assign w_div_res = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF}
                    : {(w_neg_r ? (~w_rmd + 32'd1) : w_rmd),
                       (w_neg_q ? (~w_quo + 32'd1) : w_quo)};

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: w_next gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (valid) begin
                  w_next = op[1] ? S_DIV : S_MUL;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_MUL:   w_next = S_DONE;
            S_DIV:   w_next = (r_cnt == 5'd31) ? S_FIX : S_DIV;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_op   <= 2'b00;
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_dvsr <= 32'd0;
         r_rem  <= 64'd0;
         r_cnt  <= 5'd0;
         r_hilo <= 64'd0;
      end else begin
         if (w_accept) begin
            r_op   <= op;
            r_a    <= a;
            r_b    <= b;
            r_dvsr <= w_b_mag;
            r_rem  <= {32'd0, w_a_mag};
            r_cnt  <= 5'd0;
         end else if (r_state == S_DIV) begin
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 5'd1;
         end

         // Results only land on the edge into DONE; a flush leaves them untouched.
         if (!flush) begin
            if (r_state == S_MUL) begin
               r_hilo <= w_prod;
            end else if (r_state == S_FIX) begin
               r_hilo <= w_div_res;
            end
         end
      end
   end

   assign busy = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
   assign done = (r_state == S_DONE);
   assign hi   = r_hilo[63:32];
   assign lo   = r_hilo[31:0];

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        valid;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [63:0] held;

   muldiv_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .valid  (valid),
      .op     (op),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: {hi, lo} from plain 64-bit integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                         input logic [31:0] mb);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      logic [63:0]     q;
      logic [63:0]     r;
      sa = $signed(ma);
      sb = $signed(mb);
      ua = {32'd0, ma};
      ub = {32'd0, mb};
      case (mop)
         2'b00: begin q = sa * sb; return q; end
         2'b01: begin q = ua * ub; return q; end
         2'b10: begin
            if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
            q = ua / ub;
            r = ua % ub;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Starts at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
   task automatic run_op(input logic [1:0] top, input logic [31:0] ta, input logic [31:0] tb_v,
                         input string tag);
      int          lat;
      int          busy_cnt;
      int          done_cnt;
      logic [63:0] exp;
      exp      = model(top, ta, tb_v);
      lat      = top[1] ? 34 : 2;
      busy_cnt = 0;
      done_cnt = 0;
      valid = 1'b1;
      op    = top;
      a     = ta;
      b     = tb_v;
      flush = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int c = 1; c < lat; c++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done !== 1'b0) done_cnt++;
         // Requests while busy must be ignored.
         valid = 1'($urandom_range(0, 1));
         op    = 2'($urandom);
         a     = $urandom;
         b     = $urandom;
         @(negedge clk);
      end
      valid = 1'b0;
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
      check({tag, "_done_early"}, 64'(done_cnt), 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd1);
      check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      check({tag, "_hilo"}, {hi, lo}, exp);
      held = exp;
   endtask

   task automatic idle_check(input string tag);
      valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check({tag, "_idle_ctl"}, {62'd0, busy, done}, 64'd0);
      check({tag, "_idle_hold"}, {hi, lo}, held);
   endtask

   initial begin
      int done_cnt;
      resetn = 1'b0;
      valid  = 1'b0;
      flush  = 1'b0;
      op     = 2'b00;
      a      = 32'd0;
      b      = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_out", {busy, done, hi, lo}, 66'd0);
      resetn = 1'b1;
      held   = 64'd0;
      @(negedge clk);

      run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
      check("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      idle_check("mult");

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
      check("plan_multu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      idle_check("multu");

      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div");
      check("plan_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      run_op(2'b11, 32'h8000_0000, 32'h0000_0003, "divu");
      check("plan_divu", {hi, lo}, 64'h0000_0002_2AAA_AAAA);

      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "ovf");
      check("plan_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
      idle_check("ovf");

      // Divide by zero, then a MULT issued in its DONE cycle.
      run_op(2'b10, 32'h1234_5678, 32'h0000_0000, "dbz");
      check("plan_dbz", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
      run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, "b2b");
      idle_check("b2b");

      // Flush in cycle 10 of a DIV.
      valid = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ctl", {62'd0, busy, done}, 64'd0);
      check("flush_hold", {hi, lo}, held);
      done_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (done !== 1'b0) done_cnt++;
         @(negedge clk);
      end
      check("flush_no_done", 64'(done_cnt), 64'd0);

      // Flush together with valid: no accept.
      valid = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
      @(negedge clk);
      valid = 1'b0; flush = 1'b0;
      check("flush_valid_busy", {63'd0, busy}, 64'd0);
      idle_check("flush_valid");

      // Reset in cycle 5 of a DIV.
      valid = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'd13;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("mid_reset", {busy, done, hi, lo}, 66'd0);
      held = 64'd0;
      @(negedge clk);
      resetn = 1'b1;
      idle_check("post_reset");

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom), pick_operand(), pick_operand(), "rand");
         if ($urandom_range(0, 2) == 0) idle_check("rand");
      end
      idle_check("final");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
